// File: rtl/fp_sum_seq.sv
// Packet sequencer for a binary32 adder: folds each operand packet
// into one running sum through the adder's start/done handshake.
module fp_sum_seq #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             add_start,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  input  logic             add_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    OUTPUT,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [31:0]      acc_q, acc_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic             ov_q, ov_d;
  logic             rdy_q, rdy_d;
  logic             take;
  logic             tmo;

  assign take = in_valid & rdy_q;
  assign tmo  = (tmr_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    last_d  = last_q;
    err_d   = err_q;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          acc_d   = in_data;
          cnt_d   = CNT_W'(1);
          err_d   = 1'b0;
          state_d = in_last ? OUTPUT : ISSUE;
        end
      end
      ISSUE: begin
        if (take) begin
          a_d     = acc_q;
          b_d     = in_data;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          last_d  = in_last;
          start_d = 1'b1;
          tmr_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK, WAIT_DONE: begin
        // a done that arrives with the timer expiring still counts
        if (state_q == WAIT_DONE && add_done) begin
          acc_d   = add_sum;
          state_d = last_q ? OUTPUT : ISSUE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = last_q ? OUTPUT : DRAIN;
        end else begin
          tmr_d = tmr_q + TW'(1);
          if (state_q == WAIT_ACK && !add_done) begin
            state_d = WAIT_DONE;
          end
        end
      end
      DRAIN: begin
        if (take && in_last) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (ov_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // valid rises one cycle after entering OUTPUT
    ov_d  = (state_q == OUTPUT) && (state_d == OUTPUT);
    rdy_d = (state_d == IDLE) || (state_d == ISSUE) ||
            (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      ov_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      start_q <= start_d;
      ov_q    <= ov_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready    = rdy_q;
  assign add_start   = start_q;
  assign add_a       = a_q;
  assign add_b       = b_q;
  assign out_valid   = ov_q;
  assign out_sum     = acc_q;
  assign out_count   = cnt_q;
  assign timeout_err = err_q;

endmodule
